// File: rtl/uart_tx_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_scheduler_pkg
// Shared definitions for the UART TX scheduler slice:
//   - sched_state_t : scheduler FSM state encodings
//   - clog2_f       : ceiling log2 usable in parameter/localparam expressions
//   - max_f         : integer maximum, used to size the shared counter
// No ports (package).
// ----------------------------------------------------------------------------
package uart_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } sched_state_t;

  // Smallest r with 2**r >= n.
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// ----------------------------------------------------------------------------
// uart_tx_scheduler_if
// Bundles the requester-side and transmitter-side signals of the scheduler.
//   Requester side : REQ, REQ_DATA, REQ_PAR_EN, REQ_PAR_TYP (to scheduler),
//                    ACK (from scheduler)
//   Transmitter    : P_DATA, DATA_VALID, PAR_EN, PAR_TYP (from scheduler),
//                    Busy (to scheduler)
//   Status         : CUR_ID, ACTIVE, TIMEOUT_ERR (from scheduler)
// Modports:
//   master : the scheduler itself
//   slave  : the surrounding requesters / transmitter
// ----------------------------------------------------------------------------
interface uart_tx_scheduler_if
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  localparam int IDX_W = clog2_f(NUM_REQ);

  logic [NUM_REQ-1:0]   REQ;
  logic [8*NUM_REQ-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]   REQ_PAR_EN;
  logic [NUM_REQ-1:0]   REQ_PAR_TYP;
  logic [NUM_REQ-1:0]   ACK;
  logic [7:0]           P_DATA;
  logic                 DATA_VALID;
  logic                 PAR_EN;
  logic                 PAR_TYP;
  logic                 Busy;
  logic [IDX_W-1:0]     CUR_ID;
  logic                 ACTIVE;
  logic                 TIMEOUT_ERR;

  modport master (
    input  REQ, REQ_DATA, REQ_PAR_EN, REQ_PAR_TYP, Busy,
    output ACK, P_DATA, DATA_VALID, PAR_EN, PAR_TYP, CUR_ID, ACTIVE, TIMEOUT_ERR
  );

  modport slave (
    output REQ, REQ_DATA, REQ_PAR_EN, REQ_PAR_TYP, Busy,
    input  ACK, P_DATA, DATA_VALID, PAR_EN, PAR_TYP, CUR_ID, ACTIVE, TIMEOUT_ERR
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_scheduler_rr_arbiter
// Purely combinational round-robin arbiter.
//   req     [NUM_REQ]  : request vector
//   ptr     [IDX_W]    : index of the last granted requester
//   grant   [NUM_REQ]  : one-hot winner (all zero when no request)
//   idx     [IDX_W]    : encoded winner index
//   any_req            : at least one request is pending
// The search starts at (ptr+1) mod NUM_REQ and wraps, so the last winner
// has the lowest priority.
// ----------------------------------------------------------------------------
module uart_tx_scheduler_rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [clog2_f(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]          grant,
  output logic [clog2_f(NUM_REQ)-1:0] idx,
  output logic                        any_req
);

  localparam int IDX_W = clog2_f(NUM_REQ);

  // Outer loop walks priority order, inner loop keeps every bit select
  // constant after unrolling.
  always_comb begin
    logic found;
    found   = 1'b0;
    grant   = '0;
    idx     = '0;
    any_req = |req;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (i == (int'(ptr) + k) % NUM_REQ)) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          idx      = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// ----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmitter among NUM_REQ byte requesters using
// round-robin arbitration. A winner's byte and parity configuration are
// latched and presented with a single-cycle DATA_VALID; the transmitter's
// Busy flag is then tracked until the frame ends, followed by an enforced
// idle gap. A Busy that never rises is caught by a timeout.
// Ports:
//   CLK  : system clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : uart_tx_scheduler_if.master (requests/ACK, transmitter bus,
//          CUR_ID / ACTIVE / TIMEOUT_ERR status)
// Parameters:
//   NUM_REQ      : requesters (2..8)
//   GAP_CYCLES   : idle cycles after Busy falls before the next grant (>=0)
//   BUSY_TIMEOUT : max cycles in WAIT_BUSY before giving up (>=2)
// ----------------------------------------------------------------------------
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  uart_tx_scheduler_if.master bus
);

  localparam int IDX_W = clog2_f(NUM_REQ);
  localparam int CNT_W = clog2_f(max_f(GAP_CYCLES, BUSY_TIMEOUT) + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(max_f(GAP_CYCLES, BUSY_TIMEOUT));
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(max_f(GAP_CYCLES, 1) - 1);

  // Saturating increment: the counter never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  sched_state_t       state;
  logic [IDX_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [7:0]         p_data_q;
  logic               dv_q;
  logic               par_en_q;
  logic               par_typ_q;
  logic [IDX_W-1:0]   cur_id_q;
  logic               active_q;
  logic               to_err_q;

  logic [NUM_REQ-1:0] win_grant;
  logic [IDX_W-1:0]   win_idx;
  logic               any_req;
  logic [7:0]         win_byte;
  logic               win_par_en;
  logic               win_par_typ;

  uart_tx_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (bus.REQ),
    .ptr     (ptr_q),
    .grant   (win_grant),
    .idx     (win_idx),
    .any_req (any_req)
  );

  // Select the winner's byte and parity configuration via the one-hot grant.
  always_comb begin
    win_byte    = '0;
    win_par_en  = 1'b0;
    win_par_typ = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_grant[i]) begin
        win_byte    = bus.REQ_DATA[8*i +: 8];
        win_par_en  = bus.REQ_PAR_EN[i];
        win_par_typ = bus.REQ_PAR_TYP[i];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      ptr_q     <= IDX_W'(NUM_REQ - 1);  // requester 0 searched first
      cnt_q     <= '0;
      ack_q     <= '0;
      p_data_q  <= '0;
      dv_q      <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      cur_id_q  <= '0;
      active_q  <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      dv_q  <= 1'b0;
      ack_q <= '0;
      case (state)
        ST_IDLE: begin
          // Frame data is captured on the grant edge so it is already
          // stable while DATA_VALID is high.
          if (!bus.Busy && any_req) begin
            state     <= ST_LAUNCH;
            dv_q      <= 1'b1;
            ack_q     <= win_grant;
            p_data_q  <= win_byte;
            par_en_q  <= win_par_en;
            par_typ_q <= win_par_typ;
            cur_id_q  <= win_idx;
            active_q  <= 1'b1;
          end
        end

        ST_LAUNCH: begin
          ptr_q <= cur_id_q;
          cnt_q <= '0;
          state <= ST_WAIT_BUSY;
        end

        ST_WAIT_BUSY: begin
          if (bus.Busy) begin
            state <= ST_WAIT_DONE;
          end else if (cnt_q >= TO_LAST) begin
            to_err_q <= 1'b1;
            cnt_q    <= '0;
            if (GAP_CYCLES == 0) begin
              state    <= ST_IDLE;
              active_q <= 1'b0;
            end else begin
              state <= ST_GAP;
            end
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end

        ST_WAIT_DONE: begin
          if (!bus.Busy) begin
            cnt_q <= '0;
            if (GAP_CYCLES == 0) begin
              state    <= ST_IDLE;
              active_q <= 1'b0;
            end else begin
              state <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          if (cnt_q >= GAP_LAST) begin
            state    <= ST_IDLE;
            active_q <= 1'b0;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end

        default: begin
          state    <= ST_IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ACK         = ack_q;
  assign bus.P_DATA      = p_data_q;
  assign bus.DATA_VALID  = dv_q;
  assign bus.PAR_EN      = par_en_q;
  assign bus.PAR_TYP     = par_typ_q;
  assign bus.CUR_ID      = cur_id_q;
  assign bus.ACTIVE      = active_q;
  assign bus.TIMEOUT_ERR = to_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Directed bench for uart_tx_scheduler. Instance dut0 uses the default
// parameters (4 requesters, gap 2, timeout 16); instance dut1 uses a zero
// gap. The transmitter Busy flag is driven directly by the bench.
// ----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  uart_tx_scheduler_if #(.NUM_REQ(4)) bus0 ();
  uart_tx_scheduler_if #(.NUM_REQ(4)) bus1 ();

  uart_tx_scheduler #(
    .NUM_REQ(4), .GAP_CYCLES(2), .BUSY_TIMEOUT(16)
  ) dut0 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus0.master)
  );

  uart_tx_scheduler #(
    .NUM_REQ(4), .GAP_CYCLES(0), .BUSY_TIMEOUT(16)
  ) dut1 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus1.master)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic wait_dv(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!ok) begin
        tick();
        if (bus0.DATA_VALID === 1'b1) ok = 1'b1;
      end
    end
  endtask

  // Busy high for n edges (n >= 2 takes the FSM into WAIT_DONE).
  task automatic busy_pulse(input int n, output int dv_cnt);
    dv_cnt = 0;
    bus0.Busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus0.DATA_VALID === 1'b1) dv_cnt++;
    end
    bus0.Busy = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!ok) begin
        tick();
        if (bus0.ACTIVE === 1'b0) ok = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus0.ACK, bus0.DATA_VALID, bus0.P_DATA, bus0.PAR_EN, bus0.PAR_TYP} !== 15'h0) begin
      failures++;
      $display("FAIL reset_data: ack=%b dv=%b p_data=%h par=%b%b required all 0",
               bus0.ACK, bus0.DATA_VALID, bus0.P_DATA, bus0.PAR_EN, bus0.PAR_TYP);
    end
    checks++;
    if ({bus0.CUR_ID, bus0.ACTIVE, bus0.TIMEOUT_ERR} !== 4'h0) begin
      failures++;
      $display("FAIL reset_status: cur_id=%0d active=%b timeout=%b required all 0",
               bus0.CUR_ID, bus0.ACTIVE, bus0.TIMEOUT_ERR);
    end
    RST = 1'b0;
    tick();
    checks++;
    if (bus0.DATA_VALID !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_no_dv: dv=%b required 0", bus0.DATA_VALID);
    end
  endtask

  task automatic test_single();
    int dv_cnt;
    bus0.REQ            = 4'b0001;
    bus0.REQ_DATA[7:0]  = 8'hA5;
    bus0.REQ_PAR_EN     = 4'b0001;
    bus0.REQ_PAR_TYP    = 4'b0001;
    tick();
    checks++;
    if ({bus0.DATA_VALID, bus0.ACK} !== 5'b1_0001) begin
      failures++;
      $display("FAIL single_launch: dv=%b ack=%b required dv=1 ack=0001",
               bus0.DATA_VALID, bus0.ACK);
    end
    checks++;
    if ({bus0.P_DATA, bus0.PAR_EN, bus0.PAR_TYP, bus0.CUR_ID} !== {8'hA5, 1'b1, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL single_data: p_data=%h par_en=%b par_typ=%b cur_id=%0d required a5 1 1 0",
               bus0.P_DATA, bus0.PAR_EN, bus0.PAR_TYP, bus0.CUR_ID);
    end
    bus0.REQ = 4'b0000;
    busy_pulse(11, dv_cnt);
    checks++;
    if (dv_cnt !== 0) begin
      failures++;
      $display("FAIL single_dv_once: extra dv pulses=%0d required 0", dv_cnt);
    end
    tick();
    tick();
    checks++;
    if (bus0.ACTIVE !== 1'b1) begin
      failures++;
      $display("FAIL single_gap_active: active=%b required 1 one cycle into gap", bus0.ACTIVE);
    end
    tick();
    checks++;
    if (bus0.ACTIVE !== 1'b0) begin
      failures++;
      $display("FAIL single_gap_end: active=%b required 0 after 2 gap cycles", bus0.ACTIVE);
    end
    checks++;
    if ({bus0.P_DATA, bus0.PAR_EN} !== {8'hA5, 1'b1}) begin
      failures++;
      $display("FAIL single_hold: p_data=%h par_en=%b required a5 1", bus0.P_DATA, bus0.PAR_EN);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int dv_cnt;
    int exp_id;
    logic [7:0] exp_byte;
    apply_reset();
    bus0.REQ         = 4'b1111;
    bus0.REQ_DATA    = 32'h43_32_21_10;
    bus0.REQ_PAR_EN  = 4'b0000;
    bus0.REQ_PAR_TYP = 4'b0000;
    for (int f = 0; f < 5; f++) begin
      exp_id   = f % 4;
      exp_byte = 8'h10 + 8'(8'h11 * exp_id);
      wait_dv(30, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rr_launch_%0d: no DATA_VALID within 30 cycles", f);
      end
      checks++;
      if ({bus0.ACK, bus0.CUR_ID} !== {4'(1 << exp_id), 2'(exp_id)}) begin
        failures++;
        $display("FAIL rr_order_%0d: ack=%b cur_id=%0d required ack=%b cur_id=%0d",
                 f, bus0.ACK, bus0.CUR_ID, 4'(1 << exp_id), exp_id);
      end
      checks++;
      if (bus0.P_DATA !== exp_byte) begin
        failures++;
        $display("FAIL rr_data_%0d: p_data=%h required %h", f, bus0.P_DATA, exp_byte);
      end
      if (f == 4) bus0.REQ = 4'b0000;
      busy_pulse(3, dv_cnt);
      checks++;
      if (dv_cnt !== 0) begin
        failures++;
        $display("FAIL rr_dv_once_%0d: extra dv pulses=%0d required 0", f, dv_cnt);
      end
    end
    wait_idle(10, ok);
  endtask

  task automatic test_timeout();
    bit ok;
    int dv_cnt;
    bus0.REQ            = 4'b0010;
    bus0.REQ_DATA[15:8] = 8'h5A;
    wait_dv(20, ok);
    checks++;
    if (!ok || bus0.ACK !== 4'b0010) begin
      failures++;
      $display("FAIL to_launch: ok=%b ack=%b required ok=1 ack=0010", ok, bus0.ACK);
    end
    bus0.REQ = 4'b0000;
    for (int t = 1; t <= 19; t++) begin
      tick();
      if (t == 16) begin
        checks++;
        if (bus0.TIMEOUT_ERR !== 1'b0) begin
          failures++;
          $display("FAIL to_early: timeout=%b after 15 WAIT_BUSY cycles required 0", bus0.TIMEOUT_ERR);
        end
      end
      if (t == 17) begin
        checks++;
        if (bus0.TIMEOUT_ERR !== 1'b1) begin
          failures++;
          $display("FAIL to_set: timeout=%b after 16 WAIT_BUSY cycles required 1", bus0.TIMEOUT_ERR);
        end
      end
      if (t == 19) begin
        checks++;
        if (bus0.ACTIVE !== 1'b0) begin
          failures++;
          $display("FAIL to_via_gap: active=%b required 0 after gap", bus0.ACTIVE);
        end
      end
    end
    bus0.REQ             = 4'b0100;
    bus0.REQ_DATA[23:16] = 8'h77;
    wait_dv(20, ok);
    checks++;
    if (!ok || {bus0.ACK, bus0.P_DATA} !== {4'b0100, 8'h77}) begin
      failures++;
      $display("FAIL to_next_served: ok=%b ack=%b p_data=%h required 1 0100 77",
               ok, bus0.ACK, bus0.P_DATA);
    end
    bus0.REQ = 4'b0000;
    busy_pulse(2, dv_cnt);
    wait_idle(10, ok);
    checks++;
    if (bus0.TIMEOUT_ERR !== 1'b1) begin
      failures++;
      $display("FAIL to_sticky: timeout=%b required 1", bus0.TIMEOUT_ERR);
    end
  endtask

  task automatic test_dropped_req();
    bit ok;
    bit ack2_seen;
    int dv_cnt;
    apply_reset();
    bus0.REQ      = 4'b0001;
    bus0.REQ_DATA = 32'h33_22_00_11;
    wait_dv(20, ok);
    bus0.REQ  = 4'b0000;
    bus0.Busy = 1'b1;
    tick();
    tick();
    bus0.REQ = 4'b1100;
    tick();
    bus0.REQ = 4'b1000;
    tick();
    bus0.Busy = 1'b0;
    ack2_seen = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!ok) begin
        tick();
        if (bus0.ACK[2] === 1'b1) ack2_seen = 1'b1;
        if (bus0.DATA_VALID === 1'b1) ok = 1'b1;
      end
    end
    checks++;
    if (!ok || {bus0.ACK, bus0.CUR_ID, bus0.P_DATA} !== {4'b1000, 2'd3, 8'h33}) begin
      failures++;
      $display("FAIL drop_next_grant: ok=%b ack=%b cur_id=%0d p_data=%h required 1 1000 3 33",
               ok, bus0.ACK, bus0.CUR_ID, bus0.P_DATA);
    end
    checks++;
    if (ack2_seen !== 1'b0) begin
      failures++;
      $display("FAIL drop_no_ack2: ack2_seen=%b required 0", ack2_seen);
    end
    bus0.REQ = 4'b0000;
    busy_pulse(2, dv_cnt);
    wait_idle(10, ok);
  endtask

  task automatic test_async_reset();
    bit ok;
    bus0.REQ            = 4'b0010;
    bus0.REQ_DATA[15:8] = 8'h44;
    bus0.REQ_PAR_EN     = 4'b0010;
    wait_dv(20, ok);
    bus0.REQ  = 4'b0000;
    bus0.Busy = 1'b1;
    tick();
    tick();
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({bus0.ACK, bus0.DATA_VALID, bus0.P_DATA, bus0.PAR_EN} !== 14'h0) begin
      failures++;
      $display("FAIL arst_data: ack=%b dv=%b p_data=%h par_en=%b required all 0",
               bus0.ACK, bus0.DATA_VALID, bus0.P_DATA, bus0.PAR_EN);
    end
    checks++;
    if ({bus0.CUR_ID, bus0.ACTIVE, bus0.TIMEOUT_ERR} !== 4'h0) begin
      failures++;
      $display("FAIL arst_status: cur_id=%0d active=%b timeout=%b required all 0",
               bus0.CUR_ID, bus0.ACTIVE, bus0.TIMEOUT_ERR);
    end
    RST = 1'b0;
    bus0.Busy = 1'b0;
    bus0.REQ  = 4'b1111;
    wait_dv(20, ok);
    checks++;
    if (!ok || bus0.ACK !== 4'b0001) begin
      failures++;
      $display("FAIL arst_priority: ok=%b ack=%b required 1 0001", ok, bus0.ACK);
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (bus0.DATA_VALID !== 1'b0) begin
      failures++;
      $display("FAIL arst_dv_drop: dv=%b required 0", bus0.DATA_VALID);
    end
    RST = 1'b0;
    bus0.REQ = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_gap0_busy();
    int dv_cnt;
    bus1.Busy            = 1'b1;
    bus1.REQ             = 4'b0010;
    bus1.REQ_DATA[15:8]  = 8'hC3;
    dv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus1.DATA_VALID === 1'b1) dv_cnt++;
    end
    checks++;
    if (dv_cnt !== 0) begin
      failures++;
      $display("FAIL gap0_busy_block: dv pulses=%0d while Busy required 0", dv_cnt);
    end
    bus1.Busy = 1'b0;
    tick();
    checks++;
    if ({bus1.DATA_VALID, bus1.ACK, bus1.CUR_ID, bus1.P_DATA} !== {1'b1, 4'b0010, 2'd1, 8'hC3}) begin
      failures++;
      $display("FAIL gap0_launch: dv=%b ack=%b cur_id=%0d p_data=%h required 1 0010 1 c3",
               bus1.DATA_VALID, bus1.ACK, bus1.CUR_ID, bus1.P_DATA);
    end
    bus1.REQ  = 4'b0000;
    bus1.Busy = 1'b1;
    tick();
    tick();
    bus1.Busy = 1'b0;
    tick();
    checks++;
    if (bus1.ACTIVE !== 1'b0) begin
      failures++;
      $display("FAIL gap0_direct_idle: active=%b required 0 right after Busy falls", bus1.ACTIVE);
    end
  endtask

  initial begin
    bus0.REQ = '0; bus0.REQ_DATA = '0; bus0.REQ_PAR_EN = '0; bus0.REQ_PAR_TYP = '0; bus0.Busy = 1'b0;
    bus1.REQ = '0; bus1.REQ_DATA = '0; bus1.REQ_PAR_EN = '0; bus1.REQ_PAR_TYP = '0; bus1.Busy = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_dropped_req();
    test_async_reset();
    test_gap0_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares one UART transmitter among NUM_REQ byte requesters. It grants one requester at a time and latches that requester's byte and parity configuration. It presents the byte to the transmitter with a single-cycle DATA_VALID, then tracks the transmitter's Busy flag until the frame completes. It sits directly above the UART TX top and also enforces a minimum inter-frame idle gap and a Busy-rise timeout.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 2, idle cycles enforced after Busy falls before the next grant (0 allowed)
BUSY_TIMEOUT, 16, max cycles to wait for Busy to rise after DATA_VALID (>=2)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-high reset
REQ  input  NUM_REQ  per-requester request level; held until ACK
REQ_DATA  input  8*NUM_REQ  byte i at [8*i+7:8*i]
REQ_PAR_EN  input  NUM_REQ  per-requester parity enable
REQ_PAR_TYP  input  NUM_REQ  per-requester parity type (0 even, 1 odd)
ACK  output  NUM_REQ  one-hot, one-cycle pulse: byte accepted
P_DATA  output  8  byte to transmitter
DATA_VALID  output  1  one-cycle launch strobe to transmitter
PAR_EN  output  1  parity enable to transmitter, stable for the whole frame
PAR_TYP  output  1  parity type to transmitter, stable for the whole frame
Busy  input  1  transmitter busy flag
CUR_ID  output  clog2(NUM_REQ)  index of the current/last granted requester
ACTIVE  output  1  high from LAUNCH through end of GAP
TIMEOUT_ERR  output  1  sticky; set on Busy-rise timeout; cleared only by RST

Behaviour:
- Reset (async, RST=1): state IDLE, all outputs 0, round-robin pointer set so that requester 0 has top priority, counters 0.
- States:
  - IDLE: if Busy=0 and any REQ is set, pick the winner and go to LAUNCH. Otherwise stay.
  - LAUNCH: one cycle. DATA_VALID=1 and ACK[winner]=1. P_DATA, PAR_EN, PAR_TYP and CUR_ID are already registered with the winner's values. Go to WAIT_BUSY.
  - WAIT_BUSY: Busy=1 moves to WAIT_DONE. If the counter reaches BUSY_TIMEOUT, set TIMEOUT_ERR and go to GAP.
  - WAIT_DONE: Busy=0 moves to GAP.
  - GAP: count GAP_CYCLES cycles, then go to IDLE. With GAP_CYCLES=0, GAP lasts 0 cycles and the next state is IDLE directly.
- Grant latency: REQ is sampled in IDLE. DATA_VALID and ACK rise on the next clock edge. The winner's byte, parity config and index are registered on that same edge.
- Round-robin arbitration:
  - Search starts at (last_grant+1) mod NUM_REQ and wraps.
  - The pointer updates only on LAUNCH.
  - A requester that drops REQ before being granted is simply skipped; it receives no ACK.
- P_DATA, PAR_EN, PAR_TYP and CUR_ID hold their values from LAUNCH until the next LAUNCH. They are never changed mid-frame.
- REQ_* inputs are ignored outside IDLE.
- A requester may reassert REQ the cycle after its ACK. It then waits behind the other pending requesters.
- Busy=1 in IDLE (transmitter still in use): no grant is issued.
- Busy falling and a new REQ in the same cycle: the frame ends, GAP is honoured, and the new REQ is evaluated in IDLE.
- Reset mid-frame: returns to IDLE immediately and DATA_VALID drops asynchronously. Any frame already launched is not re-sent.
- Counters saturate and never wrap. Counter width is clog2(max(GAP_CYCLES, BUSY_TIMEOUT)+1).

Decomposition:
- Shared include file uart_defs: state encodings (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP) and a clog2 function.
- One sub-module, rr_arbiter:
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, encoded index, any_req.
  - Purely combinational.
- The scheduler FSM, counters and output registers live in uart_tx_scheduler.

Test Plan:
1. Single request: REQ=0001, REQ_DATA[7:0]=0xA5, PAR_EN=1, PAR_TYP=1, then model Busy high 11 cycles.
   Required: DATA_VALID pulses once, 1 cycle after REQ; ACK=0001; P_DATA=0xA5, PAR_EN=1, PAR_TYP=1; ACTIVE drops GAP_CYCLES=2 cycles after Busy falls.
2. All four requesters request continuously, bytes 0x10/0x21/0x32/0x43.
   Required: grant order 0,1,2,3,0; CUR_ID follows the same order; exactly one DATA_VALID per frame.
3. Transmitter never raises Busy after DATA_VALID.
   Required: TIMEOUT_ERR=1 after 16 cycles in WAIT_BUSY; the scheduler returns to IDLE via GAP; the next request is still served.
4. REQ[2] is asserted then dropped while frame 0 is in WAIT_DONE; REQ[3] is held.
   Required: next grant is 3; ACK[2] is never asserted.
5. RST asserted asynchronously during WAIT_DONE.
   Required: all outputs 0 within the same cycle; after release, requester 0 has priority.
6. GAP_CYCLES=0 and Busy already high in IDLE with REQ=0010.
   Required: no grant until Busy=0; then DATA_VALID on the next edge.
